// File: rtl/player_memory_init.sv
// Builds the starting ledger image: one {private, public, money} record per player,
// with the public key hashed through a shared table. Optional macro: MEMINIT_COLLISION_CHECK_EN.
module player_memory_init #(
    parameter int         NUM_PLAYERS = 2,
    parameter int         ROUNDS      = 8,
    parameter int         TABLE_LEN   = 32,
    parameter logic [7:0] START_MONEY = 8'd100
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [8*NUM_PLAYERS-1:0]  private_keys,
    input  logic [8*TABLE_LEN-1:0]    random_table,
    output logic                      busy,
    output logic                      done,
    output logic                      key_collision,
    output logic [24*NUM_PLAYERS-1:0] starting_memory
);
    // state  | meaning
    // IDLE   | waiting for the first start after reset
    // HASH   | one hash round per cycle, records written as players complete
    // DONE   | image valid; a new start restarts immediately
    localparam int IDXW = $clog2(TABLE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_HASH, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 p_q, p_d;
    logic [3:0]                 r_q, r_d;
    logic [7:0]                 h_q, h_d;
    logic [8*NUM_PLAYERS-1:0]   key_q, key_d;
    logic [8*TABLE_LEN-1:0]     tab_q, tab_d;
    logic [24*NUM_PLAYERS-1:0]  mem_q, mem_d;
    logic [7:0]                 key_cur;
    logic [7:0]                 t_val;
    logic [IDXW-1:0]            idx;
    logic                       last_round;
    logic                       last_player;
`ifdef MEMINIT_COLLISION_CHECK_EN
    logic                       coll_q, coll_d;
`endif

    always_comb begin
        key_cur     = key_q[8*(NUM_PLAYERS-1-int'(p_q)) +: 8];
        idx         = IDXW'(h_q ^ key_cur ^ {4'd0, r_q});
        t_val       = tab_q[8*int'(idx) +: 8];
        last_round  = (r_q == 4'(ROUNDS-1));
        last_player = (p_q == 4'(NUM_PLAYERS-1));
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        r_d     = r_q;
        h_d     = h_q;
        key_d   = key_q;
        tab_d   = tab_q;
        mem_d   = mem_q;
`ifdef MEMINIT_COLLISION_CHECK_EN
        coll_d  = coll_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    key_d   = private_keys;
                    tab_d   = random_table;
                    p_d     = 4'd0;
                    r_d     = 4'd0;
                    h_d     = 8'd0;
                    state_d = S_HASH;
`ifdef MEMINIT_COLLISION_CHECK_EN
                    coll_d  = 1'b0;
`endif
                end
            end
            S_HASH: begin
                h_d = t_val;
                r_d = r_q + 4'd1;
                if (last_round) begin
                    mem_d[24*(NUM_PLAYERS-1-int'(p_q)) +: 24] = {key_cur, t_val, START_MONEY};
`ifdef MEMINIT_COLLISION_CHECK_EN
                    // Records of earlier players in this run are already rewritten, so compare against them.
                    for (int j = 0; j < NUM_PLAYERS; j++) begin
                        if ((j < int'(p_q)) && (mem_q[24*(NUM_PLAYERS-1-j)+8 +: 8] == t_val)) begin
                            coll_d = 1'b1;
                        end
                    end
`endif
                    r_d = 4'd0;
                    h_d = 8'd0;
                    p_d = p_q + 4'd1;
                    if (last_player) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            r_q     <= '0;
            h_q     <= '0;
            key_q   <= '0;
            tab_q   <= '0;
            mem_q   <= '0;
`ifdef MEMINIT_COLLISION_CHECK_EN
            coll_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            r_q     <= r_d;
            h_q     <= h_d;
            key_q   <= key_d;
            tab_q   <= tab_d;
            mem_q   <= mem_d;
`ifdef MEMINIT_COLLISION_CHECK_EN
            coll_q  <= coll_d;
`endif
        end
    end

    assign busy            = (state_q == S_HASH);
    assign done            = (state_q == S_DONE);
    assign starting_memory = mem_q;
`ifdef MEMINIT_COLLISION_CHECK_EN
    assign key_collision   = coll_q & done;
`else
    assign key_collision   = 1'b0;
`endif

endmodule

// File: doc/player_memory_init.md
# player_memory_init

Sequential initialiser that builds the game's starting memory image for a configurable number of players. Each player record carries a private key, a Pearson-style public key and a starting balance. A single shared hash engine walks the players one after another, driven by a start/done handshake. It sits between the game controller and the ledger memory: the controller pulses `start`, and the image is loaded into memory once `done` rises.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: number of player records, from 1 to 16.
- `ROUNDS`, 8: hash rounds per key, from 1 to 16.
- `TABLE_LEN`, 32: number of table entries (bytes); must be a power of two, from 2 to 256.
- `START_MONEY`, 8'd100: balance written into every record.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `resetn` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle request to build the image.
- `private_keys` in 8·NUM_PLAYERS: player 0 occupies the MSBs.
- `random_table` in 8·TABLE_LEN: entry i is at bits [8i+7:8i].
- `busy` out 1: high while hashing.
- `done` out 1: level signal; the image is valid.
- `key_collision` out 1: two or more players have the same public key (see Configuration).
- `starting_memory` out 24·NUM_PLAYERS: one record per player, `{private, public, money}`, with player 0 in the MSBs.

## Operation
- FSM states: IDLE, HASH, DONE.
- IDLE or DONE, with `start`=1:
  - Latch `private_keys` and `random_table` into internal registers. Later changes on the input pins have no effect on the run in progress.
  - Clear `done` and `key_collision`.
  - Set player index p=0, round r=0, accumulator h=0.
  - Go to HASH.
- HASH, one round per cycle:
  - idx = low log2(TABLE_LEN) bits of (h ^ key[p] ^ r), with r zero-extended to 8 bits.
  - h ← T[idx].
  - On r=ROUNDS-1, write record p as {key[p], T[idx], START_MONEY}, then set r=0, h=0, p=p+1.
  - After the last player is written, go to DONE.
- DONE:
  - `done`=1.
  - `starting_memory` holds until the next accepted `start` or reset.
- `start` during HASH is ignored and does not restart the run.
- The bits of `starting_memory` are written only when their record completes. A restart clears `done` but leaves the old image on the pins until it is overwritten record by record. Consumers sample the image only while `done`=1.
- `busy`=1 exactly in HASH.

## Timing
- Reset value of every output is 0: `starting_memory`, `busy`, `done`, `key_collision`. The FSM enters IDLE and p, r, h are cleared.
- Reset applied mid-run aborts the run. Outputs are 0 on the cycle after the reset edge, and no partial record survives.
- Counting from the edge that accepts `start`:
  - `busy` rises after that edge.
  - The record for player p is visible after edge (p+1)·ROUNDS.
  - `done` rises, and `busy` falls, after edge NUM_PLAYERS·ROUNDS.
  - With the defaults this is 16 cycles.
- `start` in DONE is accepted on the same edge that clears `done`. There is no dead cycle.
- `start` held high is treated as one request per entry into IDLE or DONE.

## Configuration
- `MEMINIT_COLLISION_CHECK_EN` defined:
  - Each newly computed public key is compared against all earlier public keys in the current run.
  - Any match sets a sticky flag that is cleared on `start`.
  - `key_collision` shows that flag, qualified by `done`: it is 0 whenever `done`=0.
- `MEMINIT_COLLISION_CHECK_EN` not defined:
  - `key_collision` is tied to 0.
  - No comparator logic is synthesised.
- The port exists in both builds.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles, then release → all outputs 0 and `busy`=0 with no `start` applied.
- **Defaults, single table value:** defaults, `private_keys`={8'h75, 8'h1B}, every table entry 8'hA5, pulse `start` → `done` rises exactly 16 cycles after the `start` edge; `starting_memory`=48'h75A564_1BA564.
- **Identity table, one player, one round:** NUM_PLAYERS=1, ROUNDS=1, T[i]=i, key 8'h1F → after 1 cycle, record = {8'h1F, 8'h1F, 8'h64}.
- **Start and input changes mid-run:** `start` at cycle 5 of a run, and `private_keys` changed mid-run → ignored; `done` still rises at cycle 16 with the original image; a later `start` in DONE restarts, and `done` is low on the next cycle.
- **Reset mid-run:** `resetn`=0 at cycle 9 of a run → next cycle all outputs 0 and the FSM is in IDLE; a new `start` completes normally in 16 cycles.
- **Collision check:** with the macro defined, two identical keys → `key_collision`=1 together with `done`; with distinct keys and every table entry 8'hA5 (all public keys 8'hA5) → also 1; with the macro not defined → always 0.
